// File: rtl/spi_speed_controller.sv
// -----------------------------------------------------------------------------
// spi_speed_controller
//
// Takes 4-bit speed commands from the SPI slave receiver, ramps the applied
// speed toward the commanded target one LSB every RAMP_DIV cycles, and drives
// the motor PWM. A watchdog forces a safe ramp-down to zero when no command
// arrives for TIMEOUT_CYCLES. It also supplies the byte the SPI slave returns
// on MISO: 8'hA5 normally and 8'h5A while the watchdog fault is active.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   cmd_data     4-bit speed command (from spi_data_out)
//   cmd_valid    one-cycle command strobe (from spi_data_valid_out)
//   enable       motor enable; 0 stops the motor on the next edge
//   speed_target registered commanded speed
//   speed_cur    registered applied (ramped) speed
//   pwm_out      registered PWM drive, duty = speed_cur/15
//   busy         1 while ramping up or down (not while ramping in FAULT)
//   timeout_flag watchdog fault active
//   ack_byte     byte for the SPI slave MISO shift register
// -----------------------------------------------------------------------------
module spi_speed_controller #(
  parameter int RAMP_DIV       = 1000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int PWM_DIV        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd_data,
  input  logic       cmd_valid,
  input  logic       enable,
  output logic [3:0] speed_target,
  output logic [3:0] speed_cur,
  output logic       pwm_out,
  output logic       busy,
  output logic       timeout_flag,
  output logic [7:0] ack_byte
);

  localparam int RW = $clog2(RAMP_DIV);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_DIV - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_PRE     = WW'(TIMEOUT_CYCLES - 2);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);
  localparam logic [3:0]    PWM_LAST   = 4'd14;

  localparam logic [7:0] ACK_OK    = 8'hA5;
  localparam logic [7:0] ACK_FAULT = 8'h5A;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, FAULT} state_t;

  state_t        state;
  logic [RW-1:0] ramp_cnt;
  logic [WW-1:0] wd_cnt;
  logic [PW-1:0] presc_cnt;
  logic [3:0]    pwm_cnt;

  logic cmd_accept;
  logic ramp_tick;
  logic wd_expire;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  assign cmd_accept = cmd_valid && enable;
  assign ramp_tick  = (ramp_cnt == RAMP_LAST);
  // Expiry is the cycle in which the counter would reach TIMEOUT_CYCLES-1;
  // an accepted command in that same cycle suppresses it.
  assign wd_expire  = enable && !cmd_accept && (wd_cnt == WD_PRE);

  // Control FSM: ramp sequencing, command capture and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      speed_target <= 4'd0;
      speed_cur    <= 4'd0;
      ramp_cnt     <= '0;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
      busy         <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      speed_target <= 4'd0;
      speed_cur    <= 4'd0;
      ramp_cnt     <= '0;
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Direction is judged against the registered target, so a command
      // landing on a ramp tick steps toward the previous target first.
      case (state)
        IDLE: begin
          if (speed_target > speed_cur) begin
            state    <= RAMP_UP;
            busy     <= 1'b1;
            ramp_cnt <= '0;
          end else if (speed_target < speed_cur) begin
            state    <= RAMP_DOWN;
            busy     <= 1'b1;
            ramp_cnt <= '0;
          end
        end
        RAMP_UP: begin
          if (speed_target > speed_cur) begin
            if (ramp_tick) begin
              speed_cur <= sat_inc(speed_cur);
              ramp_cnt  <= '0;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end else if (speed_target < speed_cur) begin
            state    <= RAMP_DOWN;
            ramp_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RAMP_DOWN: begin
          if (speed_target < speed_cur) begin
            if (ramp_tick) begin
              speed_cur <= sat_dec(speed_cur);
              ramp_cnt  <= '0;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end else if (speed_target > speed_cur) begin
            state    <= RAMP_UP;
            ramp_cnt <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FAULT: begin
          // Safe stop: ramp down and park at zero until a command arrives.
          if (speed_cur != 4'd0) begin
            if (ramp_tick) begin
              speed_cur <= sat_dec(speed_cur);
              ramp_cnt  <= '0;
            end else begin
              ramp_cnt <= ramp_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (cmd_accept) begin
        speed_target <= cmd_data;
        wd_cnt       <= '0;
        timeout_flag <= 1'b0;
        if (state == FAULT) begin
          ramp_cnt <= '0;
          if (cmd_data == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RAMP_UP;
            busy  <= 1'b1;
          end
        end
      end else if (wd_expire) begin
        timeout_flag <= 1'b1;
        speed_target <= 4'd0;
        state        <= FAULT;
        busy         <= 1'b0;
        ramp_cnt     <= '0;
        wd_cnt       <= WD_LAST;
      end else if (wd_cnt != WD_LAST) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  // PWM generation and MISO acknowledge byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= 4'd0;
      pwm_out   <= 1'b0;
      ack_byte  <= ACK_OK;
    end else begin
      if (presc_cnt == PRESC_LAST) begin
        presc_cnt <= '0;
        pwm_cnt   <= (pwm_cnt == PWM_LAST) ? 4'd0 : pwm_cnt + 4'd1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
      // Counter spans 0..14, so speed 15 yields a constant high output.
      pwm_out  <= enable && (pwm_cnt < speed_cur);
      ack_byte <= timeout_flag ? ACK_FAULT : ACK_OK;
    end
  end

endmodule

// File: doc/spi_speed_controller.md
Name: spi_speed_controller

Overview:
- Sequences speed commands delivered by the SPI slave receiver: consumes `spi_data_out` / `spi_data_valid_out` (4-bit speed, one-cycle valid pulse, already in the `clk` domain).
- Ramps the applied speed toward the commanded target at a fixed rate and generates the motor PWM.
- Runs a command watchdog that forces a safe stop when the master goes silent.
- Supplies the byte the SPI slave returns on MISO: normal ACK 8'hA5, fault ACK 8'h5A.

Parameters:
RAMP_DIV, 1000, clk cycles per one-LSB speed step (>=2)
TIMEOUT_CYCLES, 50_000_000, clk cycles without a command before watchdog fault (>=4)
PWM_DIV, 16, clk cycles per PWM counter increment (>=1)

Ports:
clk  in  1  system clock (50 MHz nominal)
reset  in  1  asynchronous, active-high reset
cmd_data  in  4  speed command, from `spi_data_out`
cmd_valid  in  1  one-cycle command strobe, from `spi_data_valid_out`
enable  in  1  motor enable; 0 = immediate stop
speed_target  out  4  registered commanded speed
speed_cur  out  4  registered applied (ramped) speed
pwm_out  out  1  registered PWM drive
busy  out  1  1 while in RAMP_UP or RAMP_DOWN
timeout_flag  out  1  watchdog fault active
ack_byte  out  8  byte for SPI slave MISO shift register

Behaviour:
- Reset (async assert, sync release):
  - `speed_target`=0, `speed_cur`=0, `pwm_out`=0, `busy`=0, `timeout_flag`=0, `ack_byte`=8'hA5.
  - State IDLE; ramp, watchdog, prescaler and PWM counters all 0.
  - Reset asserted mid-ramp or mid-fault aborts immediately to these values.
- Command capture:
  - `cmd_valid`=1 with `enable`=1 → `speed_target` <= `cmd_data` at that edge, watchdog counter <= 0, `timeout_flag` <= 0.
  - `cmd_valid` held several cycles: each cycle is a command; last value wins.
  - `cmd_valid` while `enable`=0: ignored, no watchdog kick.
- States: IDLE, RAMP_UP, RAMP_DOWN, FAULT.
  - IDLE: `speed_cur`==`speed_target`. Go to RAMP_UP if target>cur; go to RAMP_DOWN if target<cur.
  - Entry to RAMP_UP/RAMP_DOWN clears the ramp counter. The first step occurs RAMP_DIV cycles after entry, then one step every RAMP_DIV cycles.
  - A step is `speed_cur` +/-1, with no wrap (saturates at 0/15 by construction).
  - Direction is re-evaluated every cycle against the current target. A target reversal mid-ramp switches state and restarts the ramp counter. cur==target → IDLE.
  - A ramp tick in the same cycle as a new command steps using the old target; the new target takes effect next cycle.
- Watchdog:
  - Counter increments every cycle while `enable`=1 and no command is accepted.
  - On reaching TIMEOUT_CYCLES-1: `timeout_flag` <= 1, `speed_target` <= 0, state FAULT. Counter holds (saturates).
  - FAULT ramps `speed_cur` down at the RAMP_DIV rate and stays in FAULT even at 0.
  - FAULT exits only on an accepted command → new target → RAMP_UP, or IDLE if the command is 0.
  - A command in the same cycle as expiry wins; no fault.
- `ack_byte` = 8'h5A while `timeout_flag`=1, else 8'hA5. It updates the cycle after `timeout_flag` changes (registered).
- `enable`=0:
  - Next edge: `speed_cur`=0, `speed_target`=0, state IDLE, watchdog counter held at 0, `pwm_out`=0.
  - `timeout_flag` is cleared.
- PWM:
  - Prescaler 0..PWM_DIV-1. On wrap, the PWM counter advances 0..14 and wraps to 0 (period 15 counts).
  - `pwm_out` <= (pwm_cnt < `speed_cur`) && `enable`. Speed 0 → constant 0; speed 15 → constant 1; duty = speed/15.
- `busy` is 1 exactly in RAMP_UP/RAMP_DOWN. FAULT ramping reports `busy`=0.

Test Plan:
Bench parameters: RAMP_DIV=4, TIMEOUT_CYCLES=200, PWM_DIV=1, `enable`=1 unless stated.
- Reset release, no stimulus for 150 cycles → all outputs 0, `ack_byte`=8'hA5, `pwm_out` constant 0.
- `cmd_valid` pulse with `cmd_data`=5 → `speed_target`=5 next cycle, `busy`=1, `speed_cur` steps 1,2,3,4,5 every 4 cycles, then IDLE with `busy`=0. `pwm_out` high 5 of every 15 cycles.
- At `speed_cur`=3 ramping to 10, send command 1 → RAMP_DOWN, `speed_cur` 3→2→1, then IDLE. Separately, command 15 → `pwm_out` constant 1 once `speed_cur`=15.
- Command 8, then silence → at cycle 199 after the command `timeout_flag`=1, `speed_target`=0, `ack_byte`=8'h5A one cycle later, `speed_cur` ramps 8→0. Command 4 → flag clears, `ack_byte`=8'hA5, ramp to 4.
- `cmd_valid` in exactly the expiry cycle → `timeout_flag` stays 0. Command plus ramp tick in the same cycle → step toward the old target first.
- `enable`=0 at `speed_cur`=6 → next cycle `speed_cur`=0, `pwm_out`=0, `busy`=0. Command 9 while disabled is ignored (`speed_target` stays 0). Reset asserted mid-ramp → outputs at reset values asynchronously.
